// File: rtl/wired_net_resolver.sv
// wired_net_resolver: clocked model of a multi-driven 4-state net.
// Each bit is resolved independently from NDRV driver codes under
// wire/tri, triand or trior rules, optionally with trireg charge retention
// that decays to x after DECAY consecutive undriven cycles.
// Code per bit: 00=0, 01=1, 10=z, 11=x.

// Per-bit resolver: combinational resolution plus the registered net/charge state.
module wired_net_resolver_bit #(
    parameter int NDRV   = 4,
    parameter int MODE   = 0,
    parameter int TRIREG = 0,
    parameter int DECAY  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NDRV-1:0][1:0] codes,
    output logic [1:0]           net_q,
    output logic                 held_q,
    output logic                 decay_q,
    output logic                 conflict
);
    localparam logic [1:0] C_0 = 2'b00;
    localparam logic [1:0] C_1 = 2'b01;
    localparam logic [1:0] C_Z = 2'b10;
    localparam logic [1:0] C_X = 2'b11;

    localparam int         CW           = (DECAY < 1) ? 1 : $clog2(DECAY + 1);
    localparam logic [CW-1:0] DECAY_C   = CW'(DECAY);
    localparam bit         HOLD_FOREVER = (DECAY == 0);
    localparam logic [1:0] RST_CODE     = (TRIREG != 0) ? C_X : C_Z;

    logic has0, has1, hasx;
    logic [1:0] res;

    // Summarise which driver values are present on this bit; z drivers contribute nothing.
    always_comb begin
        has0 = 1'b0;
        has1 = 1'b0;
        hasx = 1'b0;
        for (int d = 0; d < NDRV; d++) begin
            has0 = has0 | (codes[d] == C_0);
            has1 = has1 | (codes[d] == C_1);
            hasx = hasx | (codes[d] == C_X);
        end
    end

    // Net-kind resolution; with no non-z driver every kind yields z.
    always_comb begin
        res = C_Z;
        case (MODE)
            1: begin
                if (has0)      res = C_0;
                else if (hasx) res = C_X;
                else if (has1) res = C_1;
            end
            2: begin
                if (has1)      res = C_1;
                else if (hasx) res = C_X;
                else if (has0) res = C_0;
            end
            default: begin
                if (hasx || (has0 && has1)) res = C_X;
                else if (has0)              res = C_0;
                else if (has1)              res = C_1;
            end
        endcase
    end

    assign conflict = (MODE == 0) && has0 && has1;

    if (TRIREG != 0) begin : g_trireg
        logic [1:0]    stored;
        logic [CW-1:0] cnt;

        // Charge retention: a driven value recharges the node, z holds it until the decay limit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stored  <= C_X;
                cnt     <= '0;
                net_q   <= RST_CODE;
                held_q  <= 1'b0;
                decay_q <= 1'b0;
            end else if (res != C_Z) begin
                stored  <= res;
                cnt     <= '0;
                net_q   <= res;
                held_q  <= 1'b0;
                decay_q <= 1'b0;
            end else if (!stored[1]) begin
                // cnt never exceeds DECAY, so "!=" is the "<" test without a constant compare
                if (HOLD_FOREVER || (cnt != DECAY_C)) begin
                    net_q   <= stored;
                    held_q  <= 1'b1;
                    decay_q <= 1'b0;
                    if (!HOLD_FOREVER) cnt <= cnt + 1'b1;
                end else begin
                    stored  <= C_X;
                    cnt     <= '0;
                    net_q   <= C_X;
                    held_q  <= 1'b0;
                    decay_q <= 1'b1;
                end
            end else begin
                net_q   <= C_X;
                held_q  <= 1'b0;
                decay_q <= 1'b0;
            end
        end
    end else begin : g_plain
        // Plain net: register the resolved value, no retention.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) net_q <= RST_CODE;
            else     net_q <= res;
        end
        assign held_q  = 1'b0;
        assign decay_q = 1'b0;
    end
endmodule

// Top: slices the flat driver bus per bit, instantiates one resolver per bit,
// and tracks the registered conflict flag with a saturating cycle counter.
module wired_net_resolver #(
    parameter int WIDTH  = 8,
    parameter int NDRV   = 4,
    parameter int MODE   = 0,
    parameter int TRIREG = 0,
    parameter int DECAY  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NDRV*WIDTH*2-1:0] drv,
    output logic [WIDTH*2-1:0]      net_q,
    output logic [WIDTH-1:0]        held_q,
    output logic [WIDTH-1:0]        decay_q,
    output logic                    conflict_q,
    output logic [15:0]             conflict_cnt
);
    if ((MODE < 0) || (MODE > 2)) begin : g_bad_mode
        $error("wired_net_resolver: MODE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] conflict_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [NDRV-1:0][1:0] codes;
        for (genvar d = 0; d < NDRV; d++) begin : g_drv
            assign codes[d] = drv[(d*WIDTH+i)*2 +: 2];
        end

        wired_net_resolver_bit #(
            .NDRV   (NDRV),
            .MODE   (MODE),
            .TRIREG (TRIREG),
            .DECAY  (DECAY)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .codes    (codes),
            .net_q    (net_q[i*2 +: 2]),
            .held_q   (held_q[i]),
            .decay_q  (decay_q[i]),
            .conflict (conflict_bits[i])
        );
    end

    // Register the any-bit conflict and count cycles where the registered flag is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q   <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            conflict_q <= |conflict_bits;
            if (conflict_q && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wired_net_resolver.sv
// Bench for wired_net_resolver: four instances (wire, triand, trior, trireg
// with DECAY=3) share one 2-driver, 4-bit stimulus bus. A pairwise-fold
// reference model pushes expected outputs to a scoreboard queue when each
// vector is driven; they are popped and compared after the next clock edge.
module tb_wired_net_resolver;
    localparam logic [1:0] C0 = 2'b00;
    localparam logic [1:0] C1 = 2'b01;
    localparam logic [1:0] CZ = 2'b10;
    localparam logic [1:0] CX = 2'b11;
    localparam logic [7:0] ZZ = 8'b10_10_10_10;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      drv;
    logic [3:0][7:0]  net_o;
    logic [3:0][3:0]  held_o, dec_o;
    logic [3:0]       conf_o;
    logic [3:0][15:0] cnt_o;

    typedef struct packed {
        logic [3:0][7:0]  net;
        logic [3:0][3:0]  held;
        logic [3:0][3:0]  dec;
        logic [3:0]       conf;
        logic [3:0][15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // model state
    logic [1:0]  st [4];
    int          ch [4];
    logic        conf_m;
    logic [15:0] cnt_m;

    always #5 clk = ~clk;

    wired_net_resolver #(.WIDTH(4), .NDRV(2), .MODE(0), .TRIREG(0), .DECAY(3)) u_wire (
        .clk(clk), .rst(rst), .drv(drv), .net_q(net_o[0]), .held_q(held_o[0]),
        .decay_q(dec_o[0]), .conflict_q(conf_o[0]), .conflict_cnt(cnt_o[0]));
    wired_net_resolver #(.WIDTH(4), .NDRV(2), .MODE(1), .TRIREG(0), .DECAY(3)) u_and (
        .clk(clk), .rst(rst), .drv(drv), .net_q(net_o[1]), .held_q(held_o[1]),
        .decay_q(dec_o[1]), .conflict_q(conf_o[1]), .conflict_cnt(cnt_o[1]));
    wired_net_resolver #(.WIDTH(4), .NDRV(2), .MODE(2), .TRIREG(0), .DECAY(3)) u_or (
        .clk(clk), .rst(rst), .drv(drv), .net_q(net_o[2]), .held_q(held_o[2]),
        .decay_q(dec_o[2]), .conflict_q(conf_o[2]), .conflict_cnt(cnt_o[2]));
    wired_net_resolver #(.WIDTH(4), .NDRV(2), .MODE(0), .TRIREG(1), .DECAY(3)) u_treg (
        .clk(clk), .rst(rst), .drv(drv), .net_q(net_o[3]), .held_q(held_o[3]),
        .decay_q(dec_o[3]), .conflict_q(conf_o[3]), .conflict_cnt(cnt_o[3]));

    // Two-driver resolution as a fold: z is the identity element of every net kind.
    function automatic logic [1:0] rs(input int mode, input logic [1:0] a, input logic [1:0] b);
        if (a == CZ) return b;
        if (b == CZ) return a;
        if (mode == 1) return (a == C0 || b == C0) ? C0 : ((a == CX || b == CX) ? CX : C1);
        if (mode == 2) return (a == C1 || b == C1) ? C1 : ((a == CX || b == CX) ? CX : C0);
        return (a == b) ? a : CX;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin st[i] = CX; ch[i] = 0; end
        conf_m = 1'b0;
        cnt_m  = 16'd0;
    endtask

    // Advance the model by one edge for the vector currently on drv.
    task automatic model_step(output exp_t e);
        logic [1:0] a, b, r;
        logic cf;
        e  = '0;
        cf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = drv[i*2 +: 2];
            b = drv[(4+i)*2 +: 2];
            e.net[0][i*2 +: 2] = rs(0, a, b);
            e.net[1][i*2 +: 2] = rs(1, a, b);
            e.net[2][i*2 +: 2] = rs(2, a, b);
            if ((a == C0 && b == C1) || (a == C1 && b == C0)) cf = 1'b1;
            r = rs(0, a, b);
            if (r != CZ) begin
                st[i] = r; ch[i] = 0; e.net[3][i*2 +: 2] = r;
            end else if (st[i] == CX) begin
                e.net[3][i*2 +: 2] = CX;
            end else if (ch[i] < 3) begin
                e.net[3][i*2 +: 2] = st[i]; e.held[3][i] = 1'b1; ch[i]++;
            end else begin
                st[i] = CX; ch[i] = 0; e.net[3][i*2 +: 2] = CX; e.dec[3][i] = 1'b1;
            end
        end
        if (conf_m && cnt_m != 16'hFFFF) cnt_m++;
        conf_m    = cf;
        e.conf[0] = conf_m;
        e.conf[3] = conf_m;
        e.cnt[0]  = cnt_m;
        e.cnt[3]  = cnt_m;
    endtask

    task automatic compare(input exp_t e);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("net%0d", k),  16'(net_o[k]),  16'(e.net[k]));
            chk($sformatf("held%0d", k), 16'(held_o[k]), 16'(e.held[k]));
            chk($sformatf("dec%0d", k),  16'(dec_o[k]),  16'(e.dec[k]));
            chk($sformatf("conf%0d", k), 16'(conf_o[k]), 16'(e.conf[k]));
            chk($sformatf("cnt%0d", k),  cnt_o[k],       e.cnt[k]);
        end
    endtask

    // Drive one vector (driver1 byte, driver0 byte), push its expectation, check after the edge.
    task automatic step(input logic [7:0] d1, input logic [7:0] d0);
        exp_t e;
        drv = {d1, d0};
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_net0"}, 16'(net_o[0]), 16'h00AA);
        chk({tag, "_net1"}, 16'(net_o[1]), 16'h00AA);
        chk({tag, "_net2"}, 16'(net_o[2]), 16'h00AA);
        chk({tag, "_net3"}, 16'(net_o[3]), 16'h00FF);
        chk({tag, "_held"}, 16'(held_o),   16'h0000);
        chk({tag, "_dec"},  16'(dec_o),    16'h0000);
        chk({tag, "_conf"}, 16'(conf_o),   16'h0000);
        chk({tag, "_cnt0"}, cnt_o[0],      16'h0000);
        chk({tag, "_cnt3"}, cnt_o[3],      16'h0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drv = {ZZ, ZZ};
        model_reset();
        #12;
        chk_reset("reset");
        #1 rst = 1'b0;

        // plain drive against a z driver
        step(ZZ, 8'b00_01_00_01);
        chk("t1_net0", 16'(net_o[0]), 16'h0011);
        chk("t1_conf", 16'(conf_o[0]), 16'h0000);

        // bit0 fought 0 vs 1 for three cycles
        repeat (3) step(8'b10_10_10_01, 8'b10_10_10_00);
        chk("t2_net0", 16'(net_o[0]), 16'h00AB);
        chk("t2_conf", 16'(conf_o[0]), 16'h0001);
        step(ZZ, ZZ);
        chk("t2_cnt", cnt_o[0], 16'd3);

        // and/or resolution: d0 = 1,1,x,z  d1 = 0,1,1,z (bits 0..3)
        step(8'b10_01_01_00, 8'b10_11_01_01);
        chk("t3_and", 16'(net_o[1]), 16'h00B4);
        chk("t3_or",  16'(net_o[2]), 16'h0095);
        chk("t3_wire", 16'(net_o[0]), 16'h00B7);

        // trireg hold for DECAY cycles, then decay to x
        step(ZZ, 8'b10_10_10_01);
        for (int n = 0; n < 3; n++) begin
            step(ZZ, ZZ);
            chk("t4_hold_net", 16'(net_o[3][1:0]), 16'h0001);
            chk("t4_hold_h",   16'(held_o[3][0]),  16'h0001);
        end
        step(ZZ, ZZ);
        chk("t4_dec_net", 16'(net_o[3][1:0]), 16'h0003);
        chk("t4_dec_p",   16'(dec_o[3][0]),   16'h0001);
        chk("t4_dec_h",   16'(held_o[3][0]),  16'h0000);
        step(ZZ, ZZ);
        chk("t4_after_net", 16'(net_o[3][1:0]), 16'h0003);
        chk("t4_after_p",   16'(dec_o[3][0]),   16'h0000);

        // new drive on the would-be decay cycle wins
        step(ZZ, 8'b10_10_10_00);
        repeat (3) step(ZZ, ZZ);
        step(ZZ, 8'b10_10_10_01);
        chk("t5_net", 16'(net_o[3][1:0]), 16'h0001);
        chk("t5_dec", 16'(dec_o[3][0]),   16'h0000);
        step(ZZ, ZZ);
        chk("t5_hold", 16'(net_o[3][1:0]), 16'h0001);
        chk("t5_held", 16'(held_o[3][0]),  16'h0001);

        // async reset mid-hold discards the charge
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk_reset("t6_async");
        #2 rst = 1'b0;
        step(ZZ, ZZ);
        chk("t6_net",  16'(net_o[3]),  16'h00FF);
        chk("t6_held", 16'(held_o[3]), 16'h0000);

        // conflict counter saturation
        repeat (65540) step(8'b10_10_10_01, 8'b10_10_10_00);
        chk("t2_sat", cnt_o[0], 16'hFFFF);
        step(ZZ, ZZ);
        chk("t2_sat_hold", cnt_o[0], 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wired_net_resolver.md
Name: wired_net_resolver

Overview:
Parametrised, clocked model of a multi-driven 4-state net: resolves NDRV drivers per bit under wire/tri, triand or trior semantics and optionally applies trireg charge retention with cycle-counted decay to x. It sits between generated multi-driver stimulus and a checker, so that resolution, charge hold and conflicts are observable cycle by cycle. It generalises single-net, fixed-shape multi-driven assigns to arbitrary width, driver count and net kind.

Parameters:
WIDTH, 8, bits per net
NDRV, 4, number of drivers (>=1)
MODE, 0, net kind: 0=wire/tri, 1=triand, 2=trior; other values are illegal (elaboration error)
TRIREG, 0, 1 enables charge retention on the resolved value
DECAY, 15, consecutive undriven cycles a stored charge survives; 0 = hold forever

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
drv  input  NDRV*WIDTH*2  per driver, per bit, 2-bit code: 00=0, 01=1, 10=z, 11=x; driver d bit i at [(d*WIDTH+i)*2 +: 2]
net_q  output  WIDTH*2  registered resolved net, same code
held_q  output  WIDTH  1 = bit currently shows retained charge
decay_q  output  WIDTH  1-cycle pulse per bit on the cycle the charge decays to x
conflict_q  output  1  registered: any bit had both a 0 and a 1 driver (MODE 0 only)
conflict_cnt  output  16  saturating count of cycles with conflict_q set

Behaviour:
- Reset (async, rst=1): net_q = all x (11) if TRIREG=1, else all z (10); stored charge = x; decay counters = 0; held_q = 0; decay_q = 0; conflict_q = 0; conflict_cnt = 0. Deassertion takes effect at the next rising clk.
- Latency: 1 cycle; net_q at edge k+1 reflects drv sampled at edge k. No handshake; the block updates every cycle.
- Combinational per-bit resolution, z drivers ignored; if all drivers are z the result is z:
  - MODE 0: all non-z drivers equal 0 -> 0; all equal 1 -> 1; any x, or a 0/1 mix -> x.
  - MODE 1: any 0 -> 0; else any x -> x; else 1.
  - MODE 2: any 1 -> 1; else any x -> x; else 0.
- Conflict: MODE 0 only, a bit with at least one 0 driver and at least one 1 driver. It is registered into conflict_q. conflict_cnt increments on each edge where the registered value is set and saturates at 0xFFFF. conflict_q is always 0 for MODE 1 and MODE 2.
- TRIREG=0: net_q = resolved value; held_q and decay_q are always 0.
- TRIREG=1, per bit, on each edge:
  - Resolved 0/1/x: store it, counter = 0, net_q = resolved, held_q = 0.
  - Resolved z and stored charge is 0/1:
    - DECAY=0, or counter < DECAY: net_q = stored, held_q = 1, counter++.
    - counter == DECAY (i.e. the (DECAY+1)th consecutive z cycle): stored = x, net_q = x, held_q = 0, decay_q = 1 for this cycle, counter = 0.
  - Resolved z and stored charge is x: net_q = x, held_q = 0.
  - Counter width is clog2(DECAY+1), minimum 1. The counter never wraps.
- Bits are fully independent. A driver becoming active on the same cycle a decay would occur wins: the new value is stored and no decay pulse is issued.
- Reset mid-hold discards stored charge immediately; the next z cycle after reset yields x, not the old value.
- NDRV=1 degenerates to a registered pass-through, plus trireg retention when TRIREG=1.

Test Plan:
1. WIDTH=4, NDRV=2, MODE=0: drv0=0101, drv1=zzzz -> net_q=0101 one cycle later, conflict_q=0.
2. MODE=0: drv0 bit0=0, drv1 bit0=1 for 3 cycles -> net_q bit0=x, conflict_q=1, conflict_cnt=3. Then force 65540 conflict cycles -> conflict_cnt holds at 0xFFFF.
3. MODE=1 with drv0=1,1,x,z and drv1=0,1,1,z (bits 0..3) -> net_q bits 0..3 = 0,1,x,z. MODE=2 with the same stimulus -> 1,1,1,z.
4. TRIREG=1, DECAY=3: drive bit0=1, then all z -> net_q bit0=1 with held_q=1 for 3 cycles; 4th z cycle: net_q=x, decay_q=1 for one cycle, held_q=0; subsequent z cycles remain x with no pulse.
5. TRIREG=1, DECAY=3: drive 0, z for 3 cycles, then drive 1 on the would-be decay cycle -> net_q=1, no decay_q; a following z cycle holds 1.
6. TRIREG=1: drive 1, z for 1 cycle (held), assert rst asynchronously mid-cycle -> net_q=x immediately; release rst with drivers z -> net_q stays x, held_q=0.
